// File: rtl/dynamic_branch_predictor_pkg.sv
// Shared predictor types, constants and instruction-decode helpers.
package dynamic_branch_predictor_pkg;

  localparam int unsigned word_width = 32;

  // Major opcode of conditional branches (B-type).
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {INIT, RUN} bp_state_e;

  // B-type immediate, sign-extended to a full word.
  function automatic logic [word_width-1:0] b_imm(input logic [word_width-1:0] inst);
    logic unused_bits;
    unused_bits = ^{inst[24:12], inst[6:0]};
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // Static fallback: backward branches taken, forward branches not taken.
  function automatic logic btfn_taken(input logic [word_width-1:0] imm);
    return imm[word_width-1];
  endfunction

endpackage

// File: rtl/dynamic_branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor.
interface dynamic_branch_predictor_if
  import dynamic_branch_predictor_pkg::*;
#(
  parameter int unsigned IDX        = 6,
  parameter int unsigned STAT_WIDTH = 32
);
  logic                  f_valid;
  logic [word_width-1:0] f_pc;
  logic [word_width-1:0] f_inst;
  logic                  p_taken;
  logic [word_width-1:0] p_target;
  logic [IDX-1:0]        p_index;
  logic                  u_valid;
  logic [IDX-1:0]        u_index;
  logic                  u_taken;
  logic                  u_mispredict;
  logic                  ready;
  logic [STAT_WIDTH-1:0] stat_branches;
  logic [STAT_WIDTH-1:0] stat_mispredicts;

  // Pipeline side: drives fetch and resolution information.
  modport master (
    output f_valid, f_pc, f_inst, u_valid, u_index, u_taken, u_mispredict,
    input  p_taken, p_target, p_index, ready, stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  f_valid, f_pc, f_inst, u_valid, u_index, u_taken, u_mispredict,
    output p_taken, p_target, p_index, ready, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/dynamic_branch_predictor_bp_counter_table.sv
// Saturating-counter table: one async read port, one training write port and
// one init write port (init wins over training).
module dynamic_branch_predictor_bp_counter_table #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned CTR_WIDTH = 2,
  localparam int unsigned IDX      = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic [IDX-1:0]       i_rd_index,
  output logic [CTR_WIDTH-1:0] o_rd_ctr,
  input  logic                 i_upd_en,
  input  logic [IDX-1:0]       i_upd_index,
  input  logic                 i_upd_taken,
  input  logic                 i_init_en,
  input  logic [IDX-1:0]       i_init_index
);
  localparam logic [CTR_WIDTH-1:0] CtrMax  = '1;
  localparam logic [CTR_WIDTH-1:0] CtrWeak = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  logic [CTR_WIDTH-1:0] r_mem [DEPTH];
  logic [CTR_WIDTH-1:0] w_cur;
  logic [CTR_WIDTH-1:0] w_next;

  assign o_rd_ctr = r_mem[i_rd_index];
  assign w_cur    = r_mem[i_upd_index];

  // Step the trained counter toward the resolved direction, clamping at the ends.
  always_comb begin
    w_next = w_cur;
    if (i_upd_taken) begin
      if (w_cur != CtrMax) w_next = w_cur + CTR_WIDTH'(1);
    end else if (w_cur != '0) begin
      w_next = w_cur - CTR_WIDTH'(1);
    end
  end

  // Table storage; the init sweep overrides any training write.
  always_ff @(posedge i_clk) begin
    if (i_init_en) begin
      r_mem[i_init_index] <= CtrWeak;
    end else if (i_upd_en) begin
      r_mem[i_upd_index] <= w_next;
    end
  end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// PC-indexed dynamic branch predictor with BTFN fallback during table init and
// saturating performance counters.
// Optional gshare indexing: define DYNAMIC_BRANCH_PREDICTOR_GHR_EN.
module dynamic_branch_predictor
  import dynamic_branch_predictor_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 32
) (
  input logic                       i_clk,
  input logic                       i_rst,
  dynamic_branch_predictor_if.slave bp
);
  localparam int unsigned IDX = $clog2(DEPTH);

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  bp_state_e             r_state;
  bp_state_e             w_state_next;
  logic [IDX-1:0]        r_sweep;
  logic [IDX-1:0]        w_sweep_next;
  logic [STAT_WIDTH-1:0] r_stat_br;
  logic [STAT_WIDTH-1:0] r_stat_mp;
  logic [word_width-1:0] w_imm;
  logic                  w_is_branch;
  logic                  w_run;
  logic                  w_dyn;
  logic                  w_init_en;
  logic                  w_upd_en;
  logic [IDX-1:0]        w_pc_index;
  logic [IDX-1:0]        w_index;
  ctr_t                  w_ctr;

  assign w_run     = (r_state == RUN);
  assign w_upd_en  = w_run & ~i_rst & bp.u_valid;
  assign w_init_en = ~w_run & ~i_rst;
  // Reset forces the static rule even if the table was already live.
  assign w_dyn     = w_run & ~i_rst;

  // State register and sweep pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_next;
      r_sweep <= w_sweep_next;
    end
  end

  // Sweep the table once after reset, then run until the next reset.
  always_comb begin
    w_state_next = r_state;
    w_sweep_next = r_sweep;
    unique case (r_state)
      INIT: begin
        w_sweep_next = r_sweep + IDX'(1);
        if (r_sweep == IDX'(DEPTH - 1)) w_state_next = RUN;
      end
      RUN: w_state_next = RUN;
    endcase
  end

  assign w_pc_index = bp.f_pc[IDX+1:2];

`ifdef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
  logic [IDX-1:0] r_ghr;

  // Global outcome history; newest outcome enters at the LSB.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ghr <= '0;
    end else if (w_upd_en) begin
      r_ghr <= {r_ghr[IDX-2:0], bp.u_taken};
    end
  end

  assign w_index = w_pc_index ^ r_ghr;
`else
  assign w_index = w_pc_index;
`endif

  dynamic_branch_predictor_bp_counter_table #(
    .DEPTH    (DEPTH),
    .CTR_WIDTH(CTR_WIDTH)
  ) u_table (
    .i_clk       (i_clk),
    .i_rd_index  (w_index),
    .o_rd_ctr    (w_ctr),
    .i_upd_en    (w_upd_en),
    .i_upd_index (bp.u_index),
    .i_upd_taken (bp.u_taken),
    .i_init_en   (w_init_en),
    .i_init_index(r_sweep)
  );

  assign w_imm       = b_imm(bp.f_inst);
  assign w_is_branch = (bp.f_inst[6:0] == OPC_BRANCH);

  assign bp.p_target = bp.f_pc + w_imm;
  assign bp.p_index  = w_index;
  assign bp.p_taken  = bp.f_valid & w_is_branch &
                       (w_dyn ? w_ctr[CTR_WIDTH-1] : btfn_taken(w_imm));
  assign bp.ready    = w_run;

  // Resolved-branch and misprediction counters, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (bp.u_valid) begin
      if (!(&r_stat_br)) r_stat_br <= r_stat_br + STAT_WIDTH'(1);
      if (bp.u_mispredict && !(&r_stat_mp)) r_stat_mp <= r_stat_mp + STAT_WIDTH'(1);
    end
  end

  assign bp.stat_branches    = r_stat_br;
  assign bp.stat_mispredicts = r_stat_mp;

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Bench for dynamic_branch_predictor: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_dynamic_branch_predictor;
  import dynamic_branch_predictor_pkg::*;

  localparam int unsigned DEPTH      = 64;
  localparam int unsigned CTR_WIDTH  = 2;
  localparam int unsigned STAT_WIDTH = 4;
  localparam int unsigned IDX        = $clog2(DEPTH);
  localparam int CtrMax  = (1 << CTR_WIDTH) - 1;
  localparam int CtrWeak = (1 << (CTR_WIDTH - 1)) - 1;
  localparam int CtrHalf = 1 << (CTR_WIDTH - 1);
  localparam int StatMax = (1 << STAT_WIDTH) - 1;
`ifdef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
  localparam bit GhrEn = 1'b1;
`else
  localparam bit GhrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dynamic_branch_predictor_if #(.IDX(IDX), .STAT_WIDTH(STAT_WIDTH)) bp_bus ();

  dynamic_branch_predictor #(
    .DEPTH     (DEPTH),
    .CTR_WIDTH (CTR_WIDTH),
    .STAT_WIDTH(STAT_WIDTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bp   (bp_bus)
  );

  // Stimulus for the current cycle.
  bit          t_rst, t_fv, t_uv, t_ut, t_um;
  logic [31:0] t_pc, t_inst;
  int          t_ui;

  // Behavioural model state.
  bit m_known, m_ready;
  int m_init, m_br, m_mp, m_ghr;
  int m_ctr [DEPTH];

  int n_cmp, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_branch(input int imm);
    logic [31:0] v;
    logic [31:0] r;
    v = imm;
    r = 32'h0;
    r[31]    = v[12];
    r[30:25] = v[10:5];
    r[11:8]  = v[4:1];
    r[7]     = v[11];
    r[6:0]   = 7'b1100011;
    return r;
  endfunction

  // Expected outputs from the rules: decode immediate arithmetically, look up
  // the model counter or apply BTFN, clamp the stat counts.
  task automatic model_check();
    int          imm, pidx, idx;
    logic [31:0] tgt;
    bit          br, tk;
    imm = (t_inst[31] ? -4096 : 0) + (t_inst[7] ? 2048 : 0)
        + int'(t_inst[30:25]) * 32 + int'(t_inst[11:8]) * 2;
    tgt  = t_pc + 32'(imm);
    br   = (t_inst[6:0] == 7'b1100011);
    pidx = int'((t_pc >> 2) & 32'(DEPTH - 1));
    idx  = GhrEn ? (pidx ^ m_ghr) : pidx;
    if (m_ready && !t_rst) tk = t_fv && br && (m_ctr[idx] >= CtrHalf);
    else tk = t_fv && br && (imm < 0);
    chk("p_taken", 32'(bp_bus.p_taken), 32'(tk));
    chk("p_target", bp_bus.p_target, tgt);
    chk("p_index", 32'(bp_bus.p_index), 32'(idx));
    chk("ready", 32'(bp_bus.ready), 32'(m_ready));
    chk("stat_branches", 32'(bp_bus.stat_branches), 32'((m_br > StatMax) ? StatMax : m_br));
    chk("stat_mispredicts", 32'(bp_bus.stat_mispredicts),
        32'((m_mp > StatMax) ? StatMax : m_mp));
  endtask

  task automatic model_advance();
    if (t_rst) begin
      m_known = 1'b1;
      m_ready = 1'b0;
      m_init  = 0;
      m_br    = 0;
      m_mp    = 0;
      m_ghr   = 0;
    end else begin
      if (t_uv) begin
        m_br++;
        if (t_um) m_mp++;
      end
      if (!m_ready) begin
        m_init++;
        if (m_init == DEPTH) begin
          m_ready = 1'b1;
          foreach (m_ctr[i]) m_ctr[i] = CtrWeak;
        end
      end else if (t_uv) begin
        if (t_ut) m_ctr[t_ui] = (m_ctr[t_ui] < CtrMax) ? m_ctr[t_ui] + 1 : CtrMax;
        else m_ctr[t_ui] = (m_ctr[t_ui] > 0) ? m_ctr[t_ui] - 1 : 0;
        m_ghr = ((m_ghr << 1) | int'(t_ut)) & (DEPTH - 1);
      end
    end
  endtask

  // Apply stimulus away from the active edge, then compare against the model.
  task automatic cycle_begin();
    @(negedge clk);
    rst                 = t_rst;
    bp_bus.f_valid      = t_fv;
    bp_bus.f_pc         = t_pc;
    bp_bus.f_inst       = t_inst;
    bp_bus.u_valid      = t_uv;
    bp_bus.u_index      = IDX'(t_ui);
    bp_bus.u_taken      = t_ut;
    bp_bus.u_mispredict = t_um;
    #1;
    if (m_known) model_check();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_advance();
  endtask

  task automatic step();
    cycle_begin();
    cycle_end();
  endtask

  task automatic set_upd(input bit uv, input int ui, input bit ut, input bit um);
    t_uv = uv;
    t_ui = ui;
    t_ut = ut;
    t_um = um;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_known = 1'b0; m_ready = 1'b0; m_init = 0; m_br = 0; m_mp = 0; m_ghr = 0;
    foreach (m_ctr[i]) m_ctr[i] = 0;
    t_rst = 1'b1; t_fv = 1'b0; t_pc = 32'h0; t_inst = 32'h0;
    set_upd(1'b0, 0, 1'b0, 1'b0);

    // Init: ready low for DEPTH cycles after reset, BTFN meanwhile.
    repeat (2) step();
    t_rst = 1'b0;
    for (int c = 0; c <= DEPTH; c++) begin
      t_fv   = 1'b1;
      t_pc   = 32'h200;
      t_inst = mk_branch((c % 2 == 1) ? -8 : 8);
      cycle_begin();
      chk("init_ready", 32'(bp_bus.ready), 32'(c == DEPTH));
      if (c == 5) chk("btfn_backward", 32'(bp_bus.p_taken), 32'd1);
      if (c == 6) chk("btfn_forward", 32'(bp_bus.p_taken), 32'd0);
      cycle_end();
    end

    // Saturation on index 3.
    t_pc   = 32'hC;
    t_inst = mk_branch(8);
    for (int k = 0; k < 5; k++) begin
      set_upd(1'b1, 3, 1'b1, 1'b0);
      step();
    end
    set_upd(1'b0, 0, 1'b0, 1'b0);
    cycle_begin();
`ifndef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
    chk("sat_max_taken", 32'(bp_bus.p_taken), 32'd1);
`endif
    cycle_end();
    set_upd(1'b1, 3, 1'b0, 1'b0);
    step();
    set_upd(1'b0, 0, 1'b0, 1'b0);
    cycle_begin();
`ifndef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
    chk("sat_dec_once", 32'(bp_bus.p_taken), 32'd1);
`endif
    cycle_end();
    set_upd(1'b1, 3, 1'b0, 1'b0);
    step();
    set_upd(1'b0, 0, 1'b0, 1'b0);
    cycle_begin();
`ifndef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
    chk("sat_dec_twice", 32'(bp_bus.p_taken), 32'd0);
`endif
    cycle_end();

    // Same-cycle predict and update on one index: no bypass.
    t_pc = 32'h100;
    set_upd(1'b1, 0, 1'b1, 1'b0);
    cycle_begin();
`ifndef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
    chk("same_cycle_old", 32'(bp_bus.p_taken), 32'd0);
`endif
    cycle_end();
    set_upd(1'b0, 0, 1'b0, 1'b0);
    cycle_begin();
`ifndef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
    chk("same_cycle_new", 32'(bp_bus.p_taken), 32'd1);
`endif
    cycle_end();

    // Non-branch against a strongly-taken counter.
    t_pc = 32'hC;
    repeat (2) begin
      set_upd(1'b1, 3, 1'b1, 1'b0);
      step();
    end
    set_upd(1'b0, 0, 1'b0, 1'b0);
    t_inst = 32'h0000_0013;
    cycle_begin();
    chk("nop_taken", 32'(bp_bus.p_taken), 32'd0);
    chk("nop_target", bp_bus.p_target, 32'hC);
    cycle_end();

    // Stats: counts, ignored lone mispredict, saturation.
    t_rst = 1'b1;
    repeat (2) step();
    t_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_upd(1'b1, k, k[0], (k % 3 == 1));
      step();
    end
    set_upd(1'b0, 0, 1'b0, 1'b1);
    step();
    cycle_begin();
    chk("stat_br_10", 32'(bp_bus.stat_branches), 32'd10);
    chk("stat_mp_3", 32'(bp_bus.stat_mispredicts), 32'd3);
    cycle_end();
    for (int k = 0; k < 10; k++) begin
      set_upd(1'b1, k, 1'b0, 1'b1);
      step();
    end
    set_upd(1'b0, 0, 1'b0, 1'b0);
    cycle_begin();
    chk("stat_br_sat", 32'(bp_bus.stat_branches), 32'd15);
    chk("stat_mp_13", 32'(bp_bus.stat_mispredicts), 32'd13);
    cycle_end();
    set_upd(1'b1, 1, 1'b0, 1'b1);
    step();
    set_upd(1'b0, 0, 1'b0, 1'b0);
    cycle_begin();
    chk("stat_br_held", 32'(bp_bus.stat_branches), 32'd15);
    chk("stat_mp_14", 32'(bp_bus.stat_mispredicts), 32'd14);
    cycle_end();

    // History T,N,T after init, then a mid-sequence reset.
    t_inst = mk_branch(8);
    repeat (DEPTH) step();
    set_upd(1'b1, 10, 1'b1, 1'b0); step();
    set_upd(1'b1, 10, 1'b0, 1'b0); step();
    set_upd(1'b1, 10, 1'b1, 1'b0); step();
    set_upd(1'b0, 0, 1'b0, 1'b0);
    t_pc = 32'hC;
    cycle_begin();
`ifdef DYNAMIC_BRANCH_PREDICTOR_GHR_EN
    chk("ghr_index", 32'(bp_bus.p_index), 32'd6);
`else
    chk("pc_index", 32'(bp_bus.p_index), 32'd3);
`endif
    cycle_end();
    t_rst = 1'b1;
    step();
    t_rst = 1'b0;
    cycle_begin();
    chk("rst_index", 32'(bp_bus.p_index), 32'd3);
    chk("rst_ready", 32'(bp_bus.ready), 32'd0);
    chk("rst_stat_br", 32'(bp_bus.stat_branches), 32'd0);
    cycle_end();
    repeat (DEPTH) step();
    t_pc = 32'h28;
    cycle_begin();
    chk("rst_ctr_weak", 32'(bp_bus.p_taken), 32'd0);
    cycle_end();

    // Randomized run against the model.
    for (int c = 0; c < 4000; c++) begin
      int idx;
      if (t_rst) t_rst = ($urandom_range(0, 2) != 0);
      else t_rst = ($urandom_range(0, 599) == 0);
      idx    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                           : int'($urandom_range(0, 7));
      t_fv   = ($urandom_range(0, 3) != 0);
      t_pc   = ($urandom & ~(32'(DEPTH - 1) << 2)) | (32'(idx) << 2);
      t_inst = $urandom;
      if ($urandom_range(0, 2) != 0) t_inst[6:0] = 7'b1100011;
      t_uv   = ($urandom_range(0, 1) == 1);
      t_ui   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                           : int'($urandom_range(0, 7));
      t_ut   = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                    : ($urandom_range(0, 3) == 0);
      t_um   = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
